// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor. It uses one full-adder slice and
// one carry flip-flop, and processes two WIDTH-bit operands LSB-first, one bit
// per clock. Operands arrive through a valid/ready handshake and results leave
// through another. Subtraction is done as A + ~B + 1. The result also reports
// the carry out of the MSB and signed overflow.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_overflow
);

  // The bit counter is at least one bit wide. It stops at LAST_BIT and never wraps.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             msb_cin_q;
  logic [CW-1:0]    cnt_q;

  logic accept;
  logic last_bit;
  logic bit_sum;
  logic bit_carry;

  assign accept    = in_valid && (state_q == IDLE);
  assign last_bit  = (cnt_q == LAST_BIT);

  // The single full-adder slice works on the current LSBs and the stored carry.
  assign bit_sum   = a_q[0] ^ b_q[0] ^ carry_q;
  assign bit_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  // State register. Reset is asynchronous and forces IDLE.
  // NOTE: sequential state uses non-blocking (<=) so that every flop samples
  // pre-edge values, whatever order the always blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode for the IDLE -> RUN -> DONE -> IDLE sequence.
  // NOTE: state_d is given a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then do one bit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      a_q       <= in_a;
      b_q       <= in_sub ? ~in_b : in_b;
      sum_q     <= '0;
      carry_q   <= in_sub;        // the +1 of the two's-complement negation
      msb_cin_q <= 1'b0;
      cnt_q     <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      sum_q   <= {bit_sum, sum_q[WIDTH-1:1]};
      carry_q <= bit_carry;
      if (last_bit) msb_cin_q <= carry_q;  // carry into the MSB slice
      else          cnt_q     <= cnt_q + CW'(1);
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_sum      = sum_q;
  assign out_carry    = carry_q;
  assign out_overflow = msb_cin_q ^ carry_q;

endmodule
